// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, load/store), the arbiter and
// the shared data memory port. The arbiter takes the slave view; the
// environment (requesters plus memory) takes the master view.
interface dmem_arbiter_if;
    logic        r0_req;
    logic        r1_req;
    logic        r0_we;
    logic        r1_we;
    logic [2:0]  r0_ctrl;
    logic [2:0]  r1_ctrl;
    logic [31:0] r0_addr;
    logic [31:0] r1_addr;
    logic [31:0] r0_wdata;
    logic [31:0] r1_wdata;
    logic        r0_gnt;
    logic        r1_gnt;
    logic        r0_done;
    logic        r1_done;
    logic [31:0] r0_rdata;
    logic [31:0] r1_rdata;
    logic        mem_valid;
    logic        mem_write;
    logic [2:0]  mem_ctrl;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ack;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  r0_req, r1_req, r0_we, r1_we, r0_ctrl, r1_ctrl,
        input  r0_addr, r1_addr, r0_wdata, r1_wdata,
        output r0_gnt, r1_gnt, r0_done, r1_done, r0_rdata, r1_rdata,
        output mem_valid, mem_write, mem_ctrl, mem_address, mem_write_data,
        input  mem_read_data, mem_ack,
        output busy, timeout_err
    );

    modport master (
        output r0_req, r1_req, r0_we, r1_we, r0_ctrl, r1_ctrl,
        output r0_addr, r1_addr, r0_wdata, r1_wdata,
        input  r0_gnt, r1_gnt, r0_done, r1_done, r0_rdata, r1_rdata,
        input  mem_valid, mem_write, mem_ctrl, mem_address, mem_write_data,
        output mem_read_data, mem_ack,
        input  busy, timeout_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data_memory port of the multicycle
// core. Requester 0 is instruction fetch, requester 1 is load/store. Each
// transaction is arbitrated in IDLE, driven to memory in ACCESS until ack or
// timeout, and reported to its owner with a one-cycle done pulse in DONE.
module dmem_arbiter #(
    parameter int TIMEOUT   = 15,  // ACCESS cycles without ack before abort (1..255)
    parameter int PRIO_MODE = 0    // 0: round-robin, 1: requester 1 wins ties
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);
    localparam logic       PRIO_FIXED_C = (PRIO_MODE == 1);

    state_t      state_r;
    logic        owner_r;
    logic        last_owner_r;
    logic        mem_valid_r;
    logic        mem_write_r;
    logic        busy_r;
    logic        timeout_err_r;
    logic        r0_done_r;
    logic        r1_done_r;
    logic [2:0]  ctrl_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] r0_rdata_r;
    logic [31:0] r1_rdata_r;
    logic [7:0]  cnt_r;

    logic        any_req_s;
    logic        win_s;
    logic        win_we_s;
    logic [2:0]  win_ctrl_s;
    logic [31:0] win_addr_s;
    logic [31:0] win_wdata_s;
    logic        r0_gnt_s;
    logic        r1_gnt_s;
    logic        timed_out_s;

    // Choose the winner among live requests and steer its fields to the latch
    always_comb begin
        any_req_s = bus.r0_req | bus.r1_req;
        win_s     = 1'b0;
        if (bus.r0_req && bus.r1_req) begin
            if (PRIO_FIXED_C) begin
                win_s = 1'b1;
            end else begin
                win_s = ~last_owner_r;
            end
        end else if (bus.r1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end

        if (win_s) begin
            win_we_s    = bus.r1_we;
            win_ctrl_s  = bus.r1_ctrl;
            win_addr_s  = bus.r1_addr;
            win_wdata_s = bus.r1_wdata;
        end else begin
            win_we_s    = bus.r0_we;
            win_ctrl_s  = bus.r0_ctrl;
            win_addr_s  = bus.r0_addr;
            win_wdata_s = bus.r0_wdata;
        end

        // Grant is same-cycle and only ever given while idle
        r0_gnt_s    = (state_r == IDLE) && bus.r0_req && !win_s;
        r1_gnt_s    = (state_r == IDLE) && bus.r1_req && win_s;
        // This ACCESS cycle is the last one allowed without an ack
        timed_out_s = ((cnt_r + 8'd1) == TIMEOUT_C);
    end

    // Transaction FSM with registered memory-side and completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            owner_r       <= 1'b0;
            last_owner_r  <= 1'b1;  // so requester 0 wins the first tie
            mem_valid_r   <= 1'b0;
            mem_write_r   <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            r0_done_r     <= 1'b0;
            r1_done_r     <= 1'b0;
            ctrl_r        <= 3'd0;
            addr_r        <= 32'd0;
            wdata_r       <= 32'd0;
            r0_rdata_r    <= 32'd0;
            r1_rdata_r    <= 32'd0;
            cnt_r         <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r     <= ACCESS;
                        owner_r     <= win_s;
                        ctrl_r      <= win_ctrl_s;
                        addr_r      <= win_addr_s;
                        wdata_r     <= win_wdata_s;
                        cnt_r       <= 8'd0;
                        mem_valid_r <= 1'b1;
                        mem_write_r <= win_we_s;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (bus.mem_ack) begin
                        // Ack beats a coincident timeout; stores leave rdata alone
                        if (!mem_write_r) begin
                            if (owner_r) begin
                                r1_rdata_r <= bus.mem_read_data;
                            end else begin
                                r0_rdata_r <= bus.mem_read_data;
                            end
                        end
                        state_r     <= DONE;
                        mem_valid_r <= 1'b0;
                        mem_write_r <= 1'b0;
                        r0_done_r   <= ~owner_r;
                        r1_done_r   <= owner_r;
                    end else if (timed_out_s) begin
                        timeout_err_r <= 1'b1;
                        if (owner_r) begin
                            r1_rdata_r <= 32'd0;
                        end else begin
                            r0_rdata_r <= 32'd0;
                        end
                        state_r     <= DONE;
                        mem_valid_r <= 1'b0;
                        mem_write_r <= 1'b0;
                        r0_done_r   <= ~owner_r;
                        r1_done_r   <= owner_r;
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                DONE: begin
                    r0_done_r    <= 1'b0;
                    r1_done_r    <= 1'b0;
                    last_owner_r <= owner_r;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_valid_r <= 1'b0;
                    mem_write_r <= 1'b0;
                    r0_done_r   <= 1'b0;
                    r1_done_r   <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.r0_gnt         = r0_gnt_s;
    assign bus.r1_gnt         = r1_gnt_s;
    assign bus.r0_done        = r0_done_r;
    assign bus.r1_done        = r1_done_r;
    assign bus.r0_rdata       = r0_rdata_r;
    assign bus.r1_rdata       = r1_rdata_r;
    assign bus.mem_valid      = mem_valid_r;
    assign bus.mem_write      = mem_write_r;
    assign bus.mem_ctrl       = ctrl_r;
    assign bus.mem_address    = addr_r;
    assign bus.mem_write_data = wdata_r;
    assign bus.busy           = busy_r;
    assign bus.timeout_err    = timeout_err_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance (dut0) and a fixed-priority
// instance (dut1), both with TIMEOUT=4, each with its own memory responder.
module tb_dmem_arbiter;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    dmem_arbiter_if if0 ();
    dmem_arbiter_if if1 ();

    dmem_arbiter #(.TIMEOUT(TO), .PRIO_MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    dmem_arbiter #(.TIMEOUT(TO), .PRIO_MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    // Memory contents seen by loads: fixed function of the address
    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h0020_0093;
        else return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory responders: ack after lat extra ACCESS cycles (255 = never)
    int vcnt0 = 0, vcnt1 = 0, lat0_v = 255, lat1_v = 255;
    bit stray0 = 1'b0;
    always @(posedge clk) vcnt0 <= if0.mem_valid ? vcnt0 + 1 : 0;
    always @(posedge clk) vcnt1 <= if1.mem_valid ? vcnt1 + 1 : 0;
    assign if0.mem_ack = (if0.mem_valid && vcnt0 == lat0_v) || (!if0.mem_valid && stray0);
    assign if1.mem_ack = if1.mem_valid && vcnt1 == lat1_v;
    assign if0.mem_read_data = if0.mem_valid ? pat(if0.mem_address) : 32'hBAD0_BAD0;
    assign if1.mem_read_data = if1.mem_valid ? pat(if1.mem_address) : 32'hBAD0_BAD0;

    typedef struct {
        bit          q0, q1, we0, we1;
        logic [2:0]  c0, c1;
        logic [31:0] a0, a1, w0, w1;
        int          lat;
        bit          own;
        int          cyc;
        logic [31:0] rd0, rd1;
        bit          terr;
    } txn_t;

    function automatic txn_t mk(input bit q0, q1, we0, we1, input logic [2:0] c0, c1,
                                input logic [31:0] a0, a1, w0, w1, input int lat,
                                input bit own, input int cyc, input logic [31:0] rd0, rd1,
                                input bit terr);
        txn_t t;
        t.q0 = q0; t.q1 = q1; t.we0 = we0; t.we1 = we1; t.c0 = c0; t.c1 = c1;
        t.a0 = a0; t.a1 = a1; t.w0 = w0; t.w1 = w1; t.lat = lat; t.own = own;
        t.cyc = cyc; t.rd0 = rd0; t.rd1 = rd1; t.terr = terr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction on dut0, entered at a negedge with dut0 idle
    task automatic run_txn(input txn_t t);
        int n;
        if0.r0_req = t.q0; if0.r0_we = t.we0; if0.r0_ctrl = t.c0;
        if0.r0_addr = t.a0; if0.r0_wdata = t.w0;
        if0.r1_req = t.q1; if0.r1_we = t.we1; if0.r1_ctrl = t.c1;
        if0.r1_addr = t.a1; if0.r1_wdata = t.w1;
        lat0_v = t.lat;
        #1;
        chk("gnt0", 32'(if0.r0_gnt), 32'(t.q0 && !t.own));
        chk("gnt1", 32'(if0.r1_gnt), 32'(t.own));
        @(posedge clk);
        #1;
        // Drop requests and scramble fields: the access must use latched values
        if0.r0_req = 1'b0; if0.r1_req = 1'b0;
        if0.r0_addr = $urandom; if0.r1_addr = $urandom;
        if0.r0_wdata = $urandom; if0.r1_wdata = $urandom;
        if0.r0_we = ~t.we0; if0.r1_we = ~t.we1;
        if0.r0_ctrl = 3'($urandom); if0.r1_ctrl = 3'($urandom);
        @(negedge clk);
        n = 0;
        while (if0.mem_valid && n < 300) begin
            chk("mem_write", 32'(if0.mem_write), 32'(t.own ? t.we1 : t.we0));
            chk("mem_address", if0.mem_address, t.own ? t.a1 : t.a0);
            chk("mem_wdata", if0.mem_write_data, t.own ? t.w1 : t.w0);
            chk("mem_ctrl", 32'(if0.mem_ctrl), 32'(t.own ? t.c1 : t.c0));
            chk("busy_access", 32'(if0.busy), 32'd1);
            n++;
            @(negedge clk);
        end
        chk("access_len", 32'(n), 32'(t.cyc));
        chk("done0", 32'(if0.r0_done), 32'(!t.own));
        chk("done1", 32'(if0.r1_done), 32'(t.own));
        chk("rdata0", if0.r0_rdata, t.rd0);
        chk("rdata1", if0.r1_rdata, t.rd1);
        chk("timeout_err", 32'(if0.timeout_err), 32'(t.terr));
        @(negedge clk);
        chk("done_clear", 32'({if0.r0_done, if0.r1_done}), 32'd0);
        chk("busy_idle", 32'(if0.busy), 32'd0);
    endtask

    txn_t        tbl[10];
    txn_t        t;
    bit          last_m, terr_m, own, acked, we;
    logic [31:0] rd_m[2];
    logic [31:0] a;
    int          g1, d0, d1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.r0_req = 1'b0; if0.r1_req = 1'b0; if0.r0_we = 1'b0; if0.r1_we = 1'b0;
        if0.r0_ctrl = 3'd0; if0.r1_ctrl = 3'd0; if0.r0_addr = 32'd0; if0.r1_addr = 32'd0;
        if0.r0_wdata = 32'd0; if0.r1_wdata = 32'd0;
        if1.r0_req = 1'b0; if1.r1_req = 1'b0; if1.r0_we = 1'b0; if1.r1_we = 1'b0;
        if1.r0_ctrl = 3'd2; if1.r1_ctrl = 3'd2; if1.r0_addr = 32'h100; if1.r1_addr = 32'h200;
        if1.r0_wdata = 32'd0; if1.r1_wdata = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_mem_valid", 32'(if0.mem_valid), 32'd0);
        chk("rst_busy", 32'(if0.busy), 32'd0);
        chk("rst_terr", 32'(if0.timeout_err), 32'd0);
        chk("rst_rdata0", if0.r0_rdata, 32'd0);
        chk("rst_addr", if0.mem_address, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Fixed priority: both held high, r1 owns every transaction
        if1.r0_req = 1'b1; if1.r1_req = 1'b1; lat1_v = 0;
        g1 = 0; d0 = 0; d1 = 0;
        #1;
        for (int i = 0; i < 12; i++) begin
            chk("prio_r0_gnt", 32'(if1.r0_gnt), 32'd0);
            if (if1.r1_gnt) g1++;
            if (if1.r1_done) d1++;
            if (if1.r0_done) d0++;
            @(negedge clk);
        end
        chk("prio_r1_grants", 32'(g1), 32'd4);
        chk("prio_r1_dones", 32'(d1), 32'd4);
        chk("prio_r0_dones", 32'(d0), 32'd0);
        if1.r1_req = 1'b0;
        #1;
        chk("prio_r0_alone", 32'(if1.r0_gnt), 32'd1);
        @(posedge clk);
        #1;
        if1.r0_req = 1'b0;
        d0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (if1.r0_done) d0++;
        end
        chk("prio_r0_served", 32'(d0), 32'd1);

        // Directed table on the round-robin instance (last owner starts at 1)
        tbl[0] = mk(1, 0, 0, 0, 3'b010, 3'b000, 32'h8, 32'h0, 32'h0, 32'h0, 0,
                    0, 1, 32'h0020_0093, 32'h0, 0);
        tbl[1] = mk(0, 1, 0, 1, 3'b000, 3'b010, 32'h0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1,
                    1, 2, 32'h0020_0093, 32'h0, 0);
        tbl[2] = mk(1, 1, 0, 0, 3'b010, 3'b100, 32'h10, 32'h14, 32'h0, 32'h0, 2,
                    0, 3, pat(32'h10), 32'h0, 0);
        tbl[3] = mk(1, 1, 0, 0, 3'b001, 3'b101, 32'h18, 32'h1C, 32'h0, 32'h0, 0,
                    1, 1, pat(32'h10), pat(32'h1C), 0);
        tbl[4] = mk(1, 1, 1, 0, 3'b000, 3'b010, 32'h20, 32'h24, 32'h1111_2222, 32'h0, 3,
                    0, 4, pat(32'h10), pat(32'h1C), 0);
        tbl[5] = mk(1, 1, 0, 0, 3'b010, 3'b011, 32'h28, 32'h2C, 32'h0, 32'h0, 1,
                    1, 2, pat(32'h10), pat(32'h2C), 0);
        tbl[6] = mk(1, 0, 0, 0, 3'b010, 3'b000, 32'h100, 32'h0, 32'h0, 32'h0, 255,
                    0, TO, 32'h0, pat(32'h2C), 1);
        tbl[7] = mk(0, 1, 0, 0, 3'b000, 3'b010, 32'h0, 32'h104, 32'h0, 32'h0, 2,
                    1, 3, 32'h0, pat(32'h104), 1);
        tbl[8] = mk(1, 0, 0, 0, 3'b110, 3'b000, 32'h108, 32'h0, 32'h0, 32'h0, 0,
                    0, 1, pat(32'h108), pat(32'h104), 1);
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Reset in the second ACCESS cycle of an r1 load (last owner is now 0)
        if0.r1_req = 1'b1; if0.r1_we = 1'b0; if0.r1_addr = 32'h200; if0.r1_ctrl = 3'b010;
        lat0_v = 255;
        @(posedge clk);
        #1;
        if0.r1_req = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(if0.mem_valid), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_mem_valid", 32'(if0.mem_valid), 32'd0);
        chk("arst_mem_write", 32'(if0.mem_write), 32'd0);
        chk("arst_busy", 32'(if0.busy), 32'd0);
        chk("arst_addr", if0.mem_address, 32'd0);
        chk("arst_rdata1", if0.r1_rdata, 32'd0);
        chk("arst_terr", 32'(if0.timeout_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_done", 32'({if0.r0_done, if0.r1_done}), 32'd0);
        end
        tbl[9] = mk(1, 1, 0, 0, 3'b010, 3'b010, 32'h30, 32'h34, 32'h0, 32'h0, 0,
                    0, 1, pat(32'h30), 32'h0, 0);
        run_txn(tbl[9]);

        // Randomized transactions against a transaction-level model
        last_m = 1'b0; terr_m = 1'b0;
        rd_m[0] = pat(32'h30); rd_m[1] = 32'h0;
        for (int k = 0; k < 40; k++) begin
            t.q0 = 1'($urandom_range(0, 1));
            t.q1 = 1'($urandom_range(0, 1));
            if (!t.q0 && !t.q1) t.q0 = 1'b1;
            t.we0 = 1'($urandom_range(0, 1)); t.we1 = 1'($urandom_range(0, 1));
            t.c0 = 3'($urandom); t.c1 = 3'($urandom);
            t.a0 = $urandom; t.a1 = $urandom; t.w0 = $urandom; t.w1 = $urandom;
            t.lat = $urandom_range(0, 5);
            own   = (t.q0 && t.q1) ? ~last_m : t.q1;
            acked = (t.lat < TO);
            we    = own ? t.we1 : t.we0;
            a     = own ? t.a1 : t.a0;
            if (acked) begin
                if (!we) rd_m[own] = pat(a);
            end else begin
                rd_m[own] = 32'h0;
                terr_m    = 1'b1;
            end
            last_m = own;
            t.own = own; t.cyc = acked ? t.lat + 1 : TO;
            t.rd0 = rd_m[0]; t.rd1 = rd_m[1]; t.terr = terr_m;
            stray0 = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(t);
        end
        stray0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
